// File: rtl/iob_clint_irq_ctrl.sv
// Per-core interrupt pending/enable/claim stage behind the CLINT, on the iob native bus.
// Optional claim counter at register 3 is built only when IOB_CLINT_IRQ_CNT_EN is defined.
module iob_clint_irq_ctrl #(
  parameter int N_CORES = 1,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [N_CORES-1:0]    mtip,
  input  logic [N_CORES-1:0]    msip,
  output logic [N_CORES-1:0]    irq
);

  typedef enum logic [1:0] {
    REG_ENABLE  = 2'd0,
    REG_PENDING = 2'd1,
    REG_CLAIM   = 2'd2,
    REG_CNT     = 2'd3
  } reg_sel_t;

  // Timer sources occupy bits [15:0], software sources bits [31:16].
  localparam logic [15:0] CORE_MASK = 16'((32'h1 << N_CORES) - 32'h1);
  localparam logic [31:0] SRC_MASK  = {CORE_MASK, CORE_MASK};

  logic [N_CORES-1:0] mtip_q, msip_q, mtip_rise, msip_rise;
  logic [31:0]        enable, pending, pm, rise, wmask, w1c, claim_clr;
  logic [31:0]        pending_d, enable_d, claim_data, rd_data;
  logic [4:0]         claim_idx;
  logic               claim_found, wr_en, rd_en;
  reg_sel_t           sel;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^address;

`ifdef IOB_CLINT_IRQ_CNT_EN
  logic [15:0] cnt;
`endif

  always_comb begin
    sel       = reg_sel_t'(address[3:2]);
    wr_en     = valid && (|wstrb);
    rd_en     = valid && !(|wstrb);
    mtip_rise = mtip & ~mtip_q;
    msip_rise = msip & ~msip_q;
    rise      = {16'(msip_rise), 16'(mtip_rise)} & SRC_MASK;
    pm        = pending & enable;

    wmask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{wstrb[b]}};
    end

    claim_found = 1'b0;
    claim_idx   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (pm[i] && !claim_found) begin
        claim_found = 1'b1;
        claim_idx   = 5'(i);
      end
    end
    claim_data = claim_found ? {1'b1, 22'b0, claim_idx[4], 4'b0, claim_idx[3:0]} : '0;

    claim_clr = '0;
    if (rd_en && sel == REG_CLAIM && claim_found) claim_clr[claim_idx] = 1'b1;
    w1c = (wr_en && sel == REG_PENDING) ? (wdata[31:0] & wmask) : '0;

    // Clears apply first so a same-cycle rising edge always survives.
    pending_d = ((pending & ~(claim_clr | w1c)) | rise) & SRC_MASK;

    enable_d = enable;
    if (wr_en && sel == REG_ENABLE)
      enable_d = ((enable & ~wmask) | (wdata[31:0] & wmask)) & SRC_MASK;

    rd_data = '0;
    case (sel)
      REG_ENABLE:  rd_data = enable;
      REG_PENDING: rd_data = pending;
      REG_CLAIM:   rd_data = claim_data;
`ifdef IOB_CLINT_IRQ_CNT_EN
      REG_CNT:     rd_data = {16'b0, cnt};
`else
      REG_CNT:     rd_data = '0;
`endif
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtip_q  <= '0;
      msip_q  <= '0;
      pending <= '0;
      enable  <= '0;
      irq     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
    end else begin
      mtip_q  <= mtip;
      msip_q  <= msip;
      pending <= pending_d;
      enable  <= enable_d;
      irq     <= pm[N_CORES-1:0] | pm[16 +: N_CORES];
      ready   <= valid;
      if (rd_en) rdata <= rd_data;
    end
  end

`ifdef IOB_CLINT_IRQ_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (wr_en && sel == REG_CNT) begin
      cnt <= '0;
    end else if (rd_en && sel == REG_CLAIM && claim_found && cnt != '1) begin
      cnt <= cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_clint_irq_ctrl.sv
// Directed table-driven bench for iob_clint_irq_ctrl (2 cores, 6-bit address),
// plus hand sequences for back-to-back access and reset mid-access.
module tb_iob_clint_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [5:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [1:0]  mtip, msip, irq;

  int total = 0;
  int bad   = 0;

`ifdef IOB_CLINT_IRQ_CNT_EN
  localparam logic [31:0] CNT_EXP = 32'd4;
`else
  localparam logic [31:0] CNT_EXP = 32'd0;
`endif

  iob_clint_irq_ctrl #(.N_CORES(2), .ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  mt;
    logic [1:0]  ms;
    logic [31:0] exp_rd;
    logic [1:0]  exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] mt, input logic [1:0] ms,
                     input logic [31:0] er, input logic [1:0] ei);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.mt = mt; v.ms = ms; v.exp_rd = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] last_rd;
    last_rd = '0;
    rst = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    mtip = '0; msip = '0;

    //  wr  addr   data          strb  mt     ms     exp_rd        irq
    add(0, 6'h00, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00); // 0
    add(0, 6'h04, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h08, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h0C, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(1, 6'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h00, 32'h0,        4'h0, 2'b00, 2'b00, 32'h00030003, 2'b00); // 5
    add(1, 6'h00, 32'h00010001, 4'h1, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h00, 32'h0,        4'h0, 2'b00, 2'b00, 32'h00030001, 2'b00);
    add(1, 6'h00, 32'h00010001, 4'hF, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h0,        2'b01);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h1,        2'b01); // 10
    add(0, 6'h08, 32'h0,        4'h0, 2'b01, 2'b00, 32'h80000000, 2'b00);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h0,        2'b00);
    add(0, 6'h04, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(1, 6'h04, 32'h1,        4'hF, 2'b01, 2'b00, 32'h0,        2'b01);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h1,        2'b01); // 15
    add(1, 6'h00, 32'h0,        4'hF, 2'b01, 2'b00, 32'h0,        2'b00);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h1,        2'b00);
    add(1, 6'h00, 32'h00010001, 4'hF, 2'b01, 2'b00, 32'h0,        2'b01);
    add(1, 6'h04, 32'h1,        4'h2, 2'b01, 2'b00, 32'h0,        2'b01);
    add(1, 6'h04, 32'h1,        4'h1, 2'b01, 2'b00, 32'h0,        2'b00); // 20
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h0,        2'b00);
    add(1, 6'h00, 32'h00030003, 4'hF, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h08, 32'h0,        4'h0, 2'b10, 2'b11, 32'h0,        2'b11);
    add(0, 6'h04, 32'h0,        4'h0, 2'b10, 2'b11, 32'h00030002, 2'b11);
    add(0, 6'h08, 32'h0,        4'h0, 2'b10, 2'b11, 32'h80000001, 2'b11); // 25
    add(0, 6'h08, 32'h0,        4'h0, 2'b10, 2'b11, 32'h80000100, 2'b10);
    add(0, 6'h08, 32'h0,        4'h0, 2'b10, 2'b11, 32'h80000101, 2'b00);
    add(0, 6'h08, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h0C, 32'h0,        4'h0, 2'b00, 2'b00, CNT_EXP,      2'b00);
    add(1, 6'h0C, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        2'b00); // 30
    add(0, 6'h0C, 32'h0,        4'h0, 2'b00, 2'b00, 32'h0,        2'b00);
    add(0, 6'h00, 32'h0,        4'h0, 2'b01, 2'b00, 32'h00030003, 2'b01);
    add(1, 6'h08, 32'hFFFFFFFF, 4'hF, 2'b01, 2'b00, 32'h0,        2'b01);
    add(0, 6'h04, 32'h0,        4'h0, 2'b01, 2'b00, 32'h1,        2'b01);
    add(1, 6'h00, 32'h0,        4'hF, 2'b01, 2'b00, 32'h0,        2'b00); // 35
    add(0, 6'h08, 32'h0,        4'h0, 2'b01, 2'b00, 32'h0,        2'b00);
    add(0, 6'h34, 32'h0,        4'h0, 2'b01, 2'b00, 32'h1,        2'b00);

    repeat (3) @(negedge clk);
    chk("reset ready", 32'(ready), 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      mtip = vecs[i].mt; msip = vecs[i].ms;
      valid = 1'b1; address = vecs[i].addr; wdata = vecs[i].data;
      wstrb = vecs[i].wr ? vecs[i].strb : 4'h0;
      @(negedge clk);
      valid = 1'b0; wstrb = 4'h0;
      chk($sformatf("v%0d ready", i), 32'(ready), 32'h1);
      if (!vecs[i].wr) last_rd = vecs[i].exp_rd;
      chk($sformatf("v%0d rdata", i), rdata, last_rd);
      @(negedge clk);
      chk($sformatf("v%0d ready_drop", i), 32'(ready), 32'h0);
      chk($sformatf("v%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Back-to-back reads: valid held high through the ready cycle.
    valid = 1'b1; address = 6'h00; wstrb = 4'h0;
    @(negedge clk);
    chk("b2b ready0", 32'(ready), 32'h1);
    chk("b2b rdata0", rdata, 32'h0);
    address = 6'h04;
    @(negedge clk);
    chk("b2b ready1", 32'(ready), 32'h1);
    chk("b2b rdata1", rdata, 32'h1);
    valid = 1'b0;
    @(negedge clk);
    chk("b2b ready_drop", 32'(ready), 32'h0);
    chk("b2b rdata_hold", rdata, 32'h1);

    // Reset asserted while ready is high.
    valid = 1'b1; address = 6'h04;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("mid ready_pre", 32'(ready), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid ready", 32'(ready), 32'h0);
    chk("mid rdata", rdata, 32'h0);
    chk("mid irq", 32'(irq), 32'h0);
    @(negedge clk);
    mtip = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    valid = 1'b1; address = 6'h04;
    @(negedge clk);
    valid = 1'b0;
    chk("post ready", 32'(ready), 32'h1);
    chk("post pending", rdata, 32'h0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
